// File: rtl/sol_ctx_regfile.sv
// Banked register file with per-bank instruction pointer, cross-bank port and
// interrupt context-switch FSM. Optional write-to-read forwarding: SOL_RF_BYPASS_EN.
module sol_ctx_regfile #(
  parameter int WIDTH      = 32,
  parameter int REG_COUNT  = 16,
  parameter int BANK_COUNT = 2,
  parameter int IRQ_BANK   = 0
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [$clog2(REG_COUNT)-1:0]  Rs1Addr,
  input  logic [$clog2(REG_COUNT)-1:0]  Rs2Addr,
  output logic [WIDTH-1:0]              Rs1Data,
  output logic [WIDTH-1:0]              Rs2Data,
  input  logic                          WrEnable,
  input  logic [$clog2(REG_COUNT)-1:0]  WrAddr,
  input  logic [WIDTH-1:0]              WrData,
  input  logic                          WrCross,
  input  logic [$clog2(BANK_COUNT)-1:0] XBank,
  input  logic [$clog2(REG_COUNT)-1:0]  XRdAddr,
  output logic [WIDTH-1:0]              XRdData,
  input  logic                          IpAdvance,
  input  logic [WIDTH-1:0]              IpNext,
  output logic [WIDTH-1:0]              Ip,
  input  logic                          IrqReq,
  output logic                          IrqAck,
  input  logic                          CtxReturn,
  output logic [$clog2(BANK_COUNT)-1:0] ActiveBank,
  output logic                          Busy
);

  localparam int BW = $clog2(BANK_COUNT);
  localparam int IP_IDX = REG_COUNT - 1;
  localparam logic [BW-1:0] IRQ_B = BW'(IRQ_BANK);

  typedef enum logic [1:0] {RUN, ENTER, LEAVE} state_e;

  state_e            state, state_nxt;
  logic [BW-1:0]     active_bank, saved_bank;
  logic [WIDTH-1:0]  regs [BANK_COUNT][REG_COUNT];
  logic [BW-1:0]     wr_bank;
  logic              xbank_ok, wr_ok, ip_adv;

  assign xbank_ok = 32'(XBank) < BANK_COUNT;
  assign wr_bank  = WrCross ? XBank : active_bank;
  assign wr_ok    = WrEnable && !Busy && (!WrCross || xbank_ok);
  assign ip_adv   = IpAdvance && !Busy;

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    IrqAck    = 1'b0;
    unique case (state)
      RUN: begin
        if (active_bank == IRQ_B) begin
          if (CtxReturn) state_nxt = LEAVE;
        end else if (IrqReq) begin
          state_nxt = ENTER;
        end
      end
      ENTER: begin
        Busy      = 1'b1;
        IrqAck    = 1'b1;
        state_nxt = RUN;
      end
      LEAVE: begin
        Busy      = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= RUN;
      active_bank <= IRQ_B;
      saved_bank  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ENTER) begin
        saved_bank  <= active_bank;
        active_bank <= IRQ_B;
      end else if (state == LEAVE) begin
        active_bank <= saved_bank;
      end
    end
  end

  // The general write is issued after the IP update so that a write to the
  // active IP slot overrides IpAdvance; writes to another bank's IP coexist.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned b = 0; b < BANK_COUNT; b++)
        for (int unsigned r = 0; r < REG_COUNT; r++)
          regs[b][r] <= '0;
    end else begin
      if (ip_adv) regs[active_bank][IP_IDX] <= IpNext;
      if (wr_ok)  regs[wr_bank][WrAddr]     <= WrData;
    end
  end

  always_comb begin
    Rs1Data = regs[active_bank][Rs1Addr];
    Rs2Data = regs[active_bank][Rs2Addr];
    XRdData = xbank_ok ? regs[XBank][XRdAddr] : '0;
`ifdef SOL_RF_BYPASS_EN
    if (wr_ok && wr_bank == active_bank && WrAddr == Rs1Addr) Rs1Data = WrData;
    if (wr_ok && wr_bank == active_bank && WrAddr == Rs2Addr) Rs2Data = WrData;
    if (wr_ok && xbank_ok && wr_bank == XBank && WrAddr == XRdAddr) XRdData = WrData;
`endif
  end

  assign Ip         = regs[active_bank][IP_IDX];
  assign ActiveBank = active_bank;

endmodule

// File: tb/tb_sol_ctx_regfile.sv
// Scoreboard bench for sol_ctx_regfile; bank 1 is the interrupt bank so the
// user bank 0 is reachable by returning from the post-reset supervisor context.
module tb_sol_ctx_regfile;

  localparam int W = 32;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [3:0]    Rs1Addr, Rs2Addr, WrAddr, XRdAddr;
  logic [W-1:0]  Rs1Data, Rs2Data, XRdData, WrData, IpNext, Ip;
  logic          WrEnable, WrCross, IpAdvance, IrqReq, IrqAck, CtxReturn, Busy;
  logic [0:0]    XBank, ActiveBank;

  sol_ctx_regfile #(.WIDTH(32), .REG_COUNT(16), .BANK_COUNT(2), .IRQ_BANK(1)) dut (
    .Clock(Clock), .Reset(Reset),
    .Rs1Addr(Rs1Addr), .Rs2Addr(Rs2Addr), .Rs1Data(Rs1Data), .Rs2Data(Rs2Data),
    .WrEnable(WrEnable), .WrAddr(WrAddr), .WrData(WrData), .WrCross(WrCross),
    .XBank(XBank), .XRdAddr(XRdAddr), .XRdData(XRdData),
    .IpAdvance(IpAdvance), .IpNext(IpNext), .Ip(Ip),
    .IrqReq(IrqReq), .IrqAck(IrqAck), .CtxReturn(CtxReturn),
    .ActiveBank(ActiveBank), .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  typedef enum int {S_RS1, S_RS2, S_XRD, S_IP, S_ACK, S_BANK, S_BUSY} sel_e;
  typedef struct {
    string        tag;
    sel_e         sel;
    logic [W-1:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] observe(input sel_e s);
    case (s)
      S_RS1:  return Rs1Data;
      S_RS2:  return Rs2Data;
      S_XRD:  return XRdData;
      S_IP:   return Ip;
      S_ACK:  return {31'b0, IrqAck};
      S_BANK: return {31'b0, ActiveBank};
      default: return {31'b0, Busy};
    endcase
  endfunction

  task automatic expect_out(input string tag, input sel_e s, input logic [W-1:0] v);
    exp_t e;
    e.tag = tag; e.sel = s; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; settle() samples combinational outputs.
  task automatic tick();   @(posedge Clock); #1; endtask
  task automatic settle(); #1; drain(); endtask

  task automatic idle();
    WrEnable = 0; WrCross = 0; IpAdvance = 0; IrqReq = 0; CtxReturn = 0;
    WrAddr = 0; WrData = 0; IpNext = 0; XBank = 0; XRdAddr = 0;
    Rs1Addr = 0; Rs2Addr = 0;
  endtask

  logic [W-1:0] byp;

  initial begin
    idle();
    Reset = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    tick();

    // Reset state: every location in both banks reads zero
    for (int a = 0; a < 16; a++) begin
      Rs1Addr = 4'(a); Rs2Addr = 4'(15 - a); XRdAddr = 4'(a); XBank = 1'(a & 1);
      expect_out("rst_rs1", S_RS1, '0);
      expect_out("rst_rs2", S_RS2, '0);
      expect_out("rst_xrd", S_XRD, '0);
      settle();
    end
    expect_out("rst_bank", S_BANK, 32'd1);
    expect_out("rst_ip",   S_IP,   '0);
    expect_out("rst_busy", S_BUSY, '0);
    expect_out("rst_ack",  S_ACK,  '0);
    settle();

    // Return to user bank 0
    CtxReturn = 1; tick(); CtxReturn = 0;
    expect_out("leave0_busy", S_BUSY, 32'd1);
    expect_out("leave0_ack",  S_ACK,  '0);
    expect_out("leave0_bank", S_BANK, 32'd1);
    settle();
    tick();
    expect_out("user_bank", S_BANK, '0);
    expect_out("user_busy", S_BUSY, '0);
    settle();

    // Write r3 in active bank 0
    WrEnable = 1; WrAddr = 3; WrData = 32'h1234_5678; Rs1Addr = 3;
`ifdef SOL_RF_BYPASS_EN
    byp = 32'h1234_5678;
`else
    byp = '0;
`endif
    expect_out("wr_same_cycle", S_RS1, byp);
    settle();
    tick(); WrEnable = 0;
    XBank = 1; XRdAddr = 3;
    expect_out("wr_r3", S_RS1, 32'h1234_5678);
    expect_out("wr_r3_other", S_XRD, '0);
    settle();

    IpAdvance = 1; IpNext = 32'h100; tick(); IpAdvance = 0;
    expect_out("ip_100", S_IP, 32'h100);
    settle();

    // Interrupt request with a write in the deciding cycle
    IrqReq = 1; WrEnable = 1; WrAddr = 2; WrData = 32'hAA; tick();
    WrData = 32'h55; IpAdvance = 1; IpNext = 32'h999;
    expect_out("enter_ack",  S_ACK,  32'd1);
    expect_out("enter_busy", S_BUSY, 32'd1);
    expect_out("enter_bank", S_BANK, '0);
    settle();
    tick(); WrEnable = 0; IpAdvance = 0;
    XBank = 0; XRdAddr = 2; Rs1Addr = 14;
    expect_out("irq_bank",  S_BANK, 32'd1);
    expect_out("ack_pulse", S_ACK,  '0);
    expect_out("r2_kept",   S_XRD,  32'hAA);
    expect_out("irq_ip",    S_IP,   '0);
    settle();
    XRdAddr = 15;
    expect_out("ip_adv_dropped", S_XRD, 32'h100);
    settle();
    tick();   // level IrqReq still high in IRQ bank: no nesting
    expect_out("nonest_ack",  S_ACK,  '0);
    expect_out("nonest_busy", S_BUSY, '0);
    settle();

    // IrqReq and CtxReturn together inside IRQ bank: return wins
    CtxReturn = 1; tick(); IrqReq = 0; CtxReturn = 0;
    expect_out("both_busy", S_BUSY, 32'd1);
    expect_out("both_ack",  S_ACK,  '0);
    settle();
    tick();
    expect_out("back_bank", S_BANK, '0);
    expect_out("back_ip",   S_IP,   32'h100);
    expect_out("back_ack",  S_ACK,  '0);
    settle();

    // IP write priority
    WrEnable = 1; WrAddr = 15; WrData = 32'h200; IpAdvance = 1; IpNext = 32'h104; tick();
    WrEnable = 0; IpNext = 32'h204;
    expect_out("ip_wr_wins", S_IP, 32'h200);
    settle();
    tick(); IpAdvance = 0;
    expect_out("ip_adv", S_IP, 32'h204);
    settle();
    WrEnable = 1; WrCross = 1; XBank = 1; WrAddr = 15; WrData = 32'h300;
    IpAdvance = 1; IpNext = 32'h208; tick();
    WrEnable = 0; WrCross = 0; IpAdvance = 0; XRdAddr = 15;
    expect_out("xip_both_ip",  S_IP,  32'h208);
    expect_out("xip_both_x",   S_XRD, 32'h300);
    settle();

    // CtxReturn outside IRQ bank is ignored
    CtxReturn = 1; tick(); CtxReturn = 0;
    expect_out("ret_ign_busy", S_BUSY, '0);
    expect_out("ret_ign_bank", S_BANK, '0);
    settle();

    // Cross-bank write
    WrEnable = 1; WrCross = 1; XBank = 1; WrAddr = 5; WrData = 32'hDEAD; tick();
    WrEnable = 0; WrCross = 0; XRdAddr = 5; Rs1Addr = 5; Rs2Addr = 3;
    expect_out("xwr_b1",  S_XRD, 32'hDEAD);
    expect_out("xwr_b0",  S_RS1, '0);
    expect_out("rs2_r3",  S_RS2, 32'h1234_5678);
    settle();

    // Reset asserted mid-ENTER
    IrqReq = 1; tick();
    expect_out("pre_rst_busy", S_BUSY, 32'd1);
    settle();
    Reset = 0; IrqReq = 0;
    expect_out("rst_mid_bank", S_BANK, 32'd1);
    expect_out("rst_mid_busy", S_BUSY, '0);
    expect_out("rst_mid_ack",  S_ACK,  '0);
    expect_out("rst_mid_x5",   S_XRD,  '0);
    settle();
    tick(); Reset = 1; tick();
    XBank = 0; XRdAddr = 3;
    expect_out("post_rst_r3", S_XRD, '0);
    expect_out("post_rst_ip", S_IP,  '0);
    settle();
    XRdAddr = 15;
    expect_out("post_rst_ip0", S_XRD, '0);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
